// File: rtl/seq_unsigned_adder.sv
// Multi-cycle unsigned adder: a+b+cin computed CHUNK bits per clock through a registered carry.
// Build option: define SEQ_ADDER_SATURATE_EN to clamp sum to all-ones when the final carry is set.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one slice per clock, slice index idx_q
// DONE  | result held on sum/carry_out until consumed, out_valid=1
module seq_unsigned_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_unsigned_adder: WIDTH must be >= 1 and a multiple of CHUNK (1 <= CHUNK <= WIDTH)");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [31:0]       slice_sh;
  logic [WIDTH-1:0]  slice_mask;
  logic [CHUNK-1:0]  a_slice;
  logic [CHUNK-1:0]  b_slice;
  logic [CHUNK:0]    slice_res;
  logic              last_slice;

  // Slices are selected by shifting rather than a variable part-select so the
  // datapath stays a plain barrel shift of the latched operands.
  assign slice_sh   = 32'(idx_q) * 32'(CHUNK);
  assign slice_mask = {WIDTH{1'b1}} >> (WIDTH - CHUNK);
  assign a_slice    = CHUNK'(a_q >> slice_sh);
  assign b_slice    = CHUNK'(b_q >> slice_sh);
  assign slice_res  = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
  assign last_slice = (idx_q == IDXW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d   = (sum_q & ~(slice_mask << slice_sh))
                | (WIDTH'(slice_res[CHUNK-1:0]) << slice_sh);
        carry_d = slice_res[CHUNK];
        if (last_slice) begin
          cout_d  = slice_res[CHUNK];
`ifdef SEQ_ADDER_SATURATE_EN
          if (slice_res[CHUNK]) begin
            sum_d = '1;
          end
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs come only from the state register, never from in_valid/out_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule
